// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU path: ALU select codes, RV32I
// funct3 values for OP/OP-IMM and BRANCH, and the branch-kind enum.
package alu_pkg;

  localparam int XLEN = 32;

  // ALU select: [3:2] picks the unit, [1:0] the variant within it
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1100;
  localparam logic [3:0] ALU_SLT  = 4'b1101;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // LT/GE cover both signed and unsigned: the compare unit already chose
  // the signedness, so only the polarity of alu_out[0] matters here.
  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4
  } br_kind_e;

  function automatic logic resolve_taken(input br_kind_e kind,
                                         input logic     zero,
                                         input logic     lsb);
    logic taken;
    case (kind)
      BR_EQ:   taken = zero;
      BR_NE:   taken = !zero;
      BR_LT:   taken = lsb;
      BR_GE:   taken = !lsb;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational micro-op decoder: funct3/funct7_5/is_imm/is_branch into an
// ALU select code, a branch kind and an illegal-encoding flag.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic       is_branch,
  input  logic       is_imm,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_sel,
  output br_kind_e   br_kind,
  output logic       illegal
);

  always_comb begin
    alu_sel = ALU_ADD;
    br_kind = BR_NONE;
    illegal = 1'b0;

    if (is_branch) begin
      case (funct3)
        F3_BEQ: begin
          alu_sel = ALU_SUB;
          br_kind = BR_EQ;
        end
        F3_BNE: begin
          alu_sel = ALU_SUB;
          br_kind = BR_NE;
        end
        F3_BLT: begin
          alu_sel = ALU_SLT;
          br_kind = BR_LT;
        end
        F3_BGE: begin
          alu_sel = ALU_SLT;
          br_kind = BR_GE;
        end
        F3_BLTU: begin
          alu_sel = ALU_SLTU;
          br_kind = BR_LT;
        end
        F3_BGEU: begin
          alu_sel = ALU_SLTU;
          br_kind = BR_GE;
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        // OP-IMM has no SUBI: bit 30 there is just immediate data
        F3_ADD_SUB: alu_sel = (funct7_5 && !is_imm) ? ALU_SUB : ALU_ADD;
        F3_SLL: begin
          if (funct7_5) illegal = 1'b1;
          else          alu_sel = ALU_SLL;
        end
        F3_SLT:     alu_sel = ALU_SLT;
        F3_SLTU:    alu_sel = ALU_SLTU;
        F3_XOR:     alu_sel = ALU_XOR;
        F3_SRL_SRA: alu_sel = funct7_5 ? ALU_SRA : ALU_SRL;
        F3_OR:      alu_sel = ALU_OR;
        F3_AND:     alu_sel = ALU_AND;
        default:    alu_sel = ALU_ADD;
      endcase
    end

    // Illegal ops park the ALU on ADD so nothing downstream toggles oddly
    if (illegal) begin
      alu_sel = ALU_ADD;
      br_kind = BR_NONE;
    end
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller around an external ALU: S1 decodes and registers
// operands, S2 captures result/flags/branch outcome behind a valid/ready port.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_is_branch,
  input  logic             in_is_imm,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7_5,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  output logic [31:0]      op1,
  output logic [31:0]      op2,
  output logic [3:0]       alu_sel,
  input  logic [31:0]      alu_out,
  input  logic             zero,
  input  logic             carry,
  input  logic             overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_taken,
  output logic             out_illegal,
  output logic             out_carry,
  output logic             out_overflow,
  output logic [CNT_W-1:0] ovf_count
);

  logic       s1_adv;
  logic       s2_adv;
  logic       out_fire;

  logic       s1_valid_reg;
  br_kind_e   s1_br_kind_reg;
  logic       s1_illegal_reg;

  logic [3:0] dec_alu_sel;
  br_kind_e   dec_br_kind;
  logic       dec_illegal;

  logic [31:0] result_next;
  logic        taken_next;
  logic        carry_next;
  logic        overflow_next;

  // Ready depends only on registered state and out_ready, never on in_valid
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv;
  assign out_fire = out_valid && out_ready;

  alu_op_decode u_decode (
    .is_branch (in_is_branch),
    .is_imm    (in_is_imm),
    .funct3    (in_funct3),
    .funct7_5  (in_funct7_5),
    .alu_sel   (dec_alu_sel),
    .br_kind   (dec_br_kind),
    .illegal   (dec_illegal)
  );

  // S1: operands only load on accept so the ALU inputs hold during a stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg   <= 1'b0;
      op1            <= '0;
      op2            <= '0;
      alu_sel        <= ALU_ADD;
      s1_br_kind_reg <= BR_NONE;
      s1_illegal_reg <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        op1            <= in_rs1;
        op2            <= in_rs2;
        alu_sel        <= dec_alu_sel;
        s1_br_kind_reg <= dec_br_kind;
        s1_illegal_reg <= dec_illegal;
      end
    end
  end

  always_comb begin
    result_next   = alu_out;
    taken_next    = resolve_taken(s1_br_kind_reg, zero, alu_out[0]);
    carry_next    = carry;
    overflow_next = overflow;
    if (s1_illegal_reg) begin
      result_next   = '0;
      taken_next    = 1'b0;
      carry_next    = 1'b0;
      overflow_next = 1'b0;
    end
  end

  // S2: payload only moves with a real op, so out_* stay put otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_taken    <= 1'b0;
      out_illegal  <= 1'b0;
      out_carry    <= 1'b0;
      out_overflow <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_result   <= result_next;
        out_taken    <= taken_next;
        out_illegal  <= s1_illegal_reg;
        out_carry    <= carry_next;
        out_overflow <= overflow_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (out_fire && out_overflow && (ovf_count != {CNT_W{1'b1}})) begin
      ovf_count <= ovf_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl with a behavioural ALU attached and an
// instruction-level reference model producing expected results.
module tb_alu_exec_ctrl;
  import alu_pkg::*;

  localparam int CNT_W = 16;
  localparam longint MAXS = 64'sh7FFF_FFFF;
  localparam longint MINS = -64'sh8000_0000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_is_branch = 1'b0;
  logic             in_is_imm = 1'b0;
  logic [2:0]       in_funct3 = '0;
  logic             in_funct7_5 = 1'b0;
  logic [31:0]      in_rs1 = '0;
  logic [31:0]      in_rs2 = '0;
  logic [31:0]      op1, op2;
  logic [3:0]       alu_sel;
  logic [31:0]      alu_out;
  logic             zero, carry, overflow;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_result;
  logic             out_taken, out_illegal, out_carry, out_overflow;
  logic [CNT_W-1:0] ovf_count;

  alu_exec_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_branch(in_is_branch), .in_is_imm(in_is_imm),
    .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .op1(op1), .op2(op2), .alu_sel(alu_sel),
    .alu_out(alu_out), .zero(zero), .carry(carry), .overflow(overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_taken(out_taken), .out_illegal(out_illegal),
    .out_carry(out_carry), .out_overflow(out_overflow),
    .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  // External ALU stand-in
  always_comb begin
    logic [32:0] t;
    logic [31:0] r;
    t = '0;
    r = '0;
    carry = 1'b0;
    overflow = 1'b0;
    case (alu_sel)
      ALU_ADD: begin
        t = {1'b0, op1} + {1'b0, op2};
        r = t[31:0];
        carry = t[32];
        overflow = (op1[31] == op2[31]) && (r[31] != op1[31]);
      end
      ALU_SUB: begin
        t = {1'b0, op1} + {1'b0, ~op2} + 33'd1;
        r = t[31:0];
        carry = t[32];
        overflow = (op1[31] != op2[31]) && (r[31] != op1[31]);
      end
      ALU_AND:  r = op1 & op2;
      ALU_OR:   r = op1 | op2;
      ALU_XOR:  r = op1 ^ op2;
      ALU_SLL:  r = op1 << op2[4:0];
      ALU_SRL:  r = op1 >> op2[4:0];
      ALU_SRA:  r = $unsigned($signed(op1) >>> op2[4:0]);
      ALU_SLTU: r = {31'd0, op1 < op2};
      ALU_SLT:  r = {31'd0, $signed(op1) < $signed(op2)};
      default:  r = '0;
    endcase
    alu_out = r;
    zero = (r == 32'd0);
  end

  typedef struct packed {
    logic [31:0] result;
    logic        taken;
    logic        illegal;
    logic        carry;
    logic        overflow;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   inflight = 0;
  int   txn = 0;
  logic [CNT_W-1:0] exp_ovf = '0;
  int   rdy_mode = 0;
  int   cyc = 0;
  int   stall_base = 0;
  bit   saw_backpressure = 0;

  bit          stalled_prev = 0;
  bit          full_prev = 0;
  logic [31:0] hold_result, hold_op1, hold_op2;
  logic [3:0]  hold_sel;
  logic [3:0]  hold_flags;

  // Instruction semantics, worked out in 64-bit integer arithmetic
  function automatic exp_t ref_model(input bit br, input bit imm, input bit [2:0] f3,
                                     input bit f75, input bit [31:0] a, input bit [31:0] b);
    exp_t   e;
    longint sa, sb, ua, ub, r;
    bit     ill;
    e = '0;
    ill = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    if (!br) begin
      case (f3)
        3'd0: begin
          if (f75 && !imm) begin
            r = sa - sb;
            e.result = 32'(ua - ub);
            e.carry = (ua >= ub);
          end else begin
            r = sa + sb;
            e.result = 32'(ua + ub);
            e.carry = ((ua + ub) > 64'sh0_FFFF_FFFF);
          end
          e.overflow = (r > MAXS) || (r < MINS);
        end
        3'd1: if (f75) ill = 1; else e.result = a << b[4:0];
        3'd2: e.result = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: e.result = (ua < ub) ? 32'd1 : 32'd0;
        3'd4: e.result = a ^ b;
        3'd5: e.result = f75 ? 32'(sa >>> b[4:0]) : (a >> b[4:0]);
        3'd6: e.result = a | b;
        default: e.result = a & b;
      endcase
    end else begin
      case (f3)
        3'd0, 3'd1: begin
          r = sa - sb;
          e.result = 32'(ua - ub);
          e.carry = (ua >= ub);
          e.overflow = (r > MAXS) || (r < MINS);
          e.taken = (a == b) ^ (f3 == 3'd1);
        end
        3'd4, 3'd5: begin
          e.result = (sa < sb) ? 32'd1 : 32'd0;
          e.taken = (sa < sb) ^ (f3 == 3'd5);
        end
        3'd6, 3'd7: begin
          e.result = (ua < ub) ? 32'd1 : 32'd0;
          e.taken = (ua < ub) ^ (f3 == 3'd7);
        end
        default: ill = 1;
      endcase
    end
    if (ill) begin
      e = '0;
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic send_op(input bit br, input bit imm, input bit [2:0] f3, input bit f75,
                         input bit [31:0] a, input bit [31:0] b);
    int waited = 0;
    bit done = 0;
    in_valid = 1'b1;
    in_is_branch = br;
    in_is_imm = imm;
    in_funct3 = f3;
    in_funct7_5 = f75;
    in_rs1 = a;
    in_rs2 = b;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(ref_model(br, imm, f3, f75, a, b));
        done = 1;
      end
      @(posedge clk);
      #1;
      waited++;
      if (!done && waited > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", waited);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_random();
    bit [31:0] a, b;
    a = ($urandom % 5 == 0) ? (($urandom % 2 == 1) ? 32'h7FFF_FFFF : 32'h8000_0000) : $urandom;
    case ($urandom % 4)
      0: b = a;
      1: b = $urandom % 40;
      default: b = $urandom;
    endcase
    send_op(1'($urandom % 3 == 0), 1'($urandom), 3'($urandom), 1'($urandom), a, b);
  endtask

  // out_ready driver: 0 = always ready, 1 = random, 2 = low for cycles 3..5
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom % 4) != 0;
        default: out_ready = !((cyc - stall_base) >= 3 && (cyc - stall_base) <= 5);
      endcase
    end
  end

  // Monitor: handshake bookkeeping, stall stability and scoreboard compare
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, !(inflight == 2 && out_valid && !out_ready)});
        if (!in_ready) saw_backpressure = 1;
        chk("ovf_count", 32'(ovf_count), 32'(exp_ovf));
        if (stalled_prev) begin
          chk("stall_result", out_result, hold_result);
          chk("stall_flags", {28'd0, out_taken, out_illegal, out_carry, out_overflow},
              {28'd0, hold_flags});
          chk("stall_valid", {31'd0, out_valid}, 32'd1);
          if (full_prev) begin
            chk("stall_op1", op1, hold_op1);
            chk("stall_op2", op2, hold_op2);
            chk("stall_sel", {28'd0, alu_sel}, {28'd0, hold_sel});
          end
        end
        stalled_prev = out_valid && !out_ready;
        full_prev = (inflight == 2);
        hold_result = out_result;
        hold_flags = {out_taken, out_illegal, out_carry, out_overflow};
        hold_op1 = op1;
        hold_op2 = op2;
        hold_sel = alu_sel;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: result 0x%08h with empty scoreboard", out_result);
          end else begin
            e = exp_q.pop_front();
            chk("result", out_result, e.result);
            chk("taken", {31'd0, out_taken}, {31'd0, e.taken});
            chk("illegal", {31'd0, out_illegal}, {31'd0, e.illegal});
            chk("carry", {31'd0, out_carry}, {31'd0, e.carry});
            chk("overflow", {31'd0, out_overflow}, {31'd0, e.overflow});
            if (e.overflow && exp_ovf != {CNT_W{1'b1}}) exp_ovf = exp_ovf + 1'b1;
            $display("txn %0d: result=0x%08h taken=%0b illegal=%0b carry=%0b ovf=%0b",
                     txn, out_result, out_taken, out_illegal, out_carry, out_overflow);
            txn++;
          end
        end
        inflight += int'(in_valid && in_ready) - int'(out_valid && out_ready);
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_op1", op1, 32'd0);
    chk("rst_op2", op2, 32'd0);
    chk("rst_alu_sel", {28'd0, alu_sel}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_flags", {28'd0, out_taken, out_illegal, out_carry, out_overflow}, 32'd0);
    chk("rst_ovf_count", 32'(ovf_count), 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // ADD 5+7 and two-cycle latency
    send_op(0, 0, 3'd0, 0, 32'd5, 32'd7);
    chk("lat_cycle1_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_cycle2_valid", {31'd0, out_valid}, 32'd1);
    chk("add_5_7", out_result, 32'd12);
    wait_drain();

    send_op(0, 0, 3'd0, 1, 32'h8000_0000, 32'd1);
    wait_drain();
    chk("sub_ovf_count", 32'(ovf_count), 32'd1);

    send_op(0, 1, 3'd5, 1, 32'hF000_0000, 32'd4);  // SRAI
    send_op(0, 1, 3'd0, 1, 32'd10, 32'd3);         // ADDI with bit30 set
    send_op(1, 0, 3'd4, 0, 32'hFFFF_FFFF, 32'd1);  // BLT
    send_op(1, 0, 3'd6, 0, 32'hFFFF_FFFF, 32'd1);  // BLTU
    send_op(1, 0, 3'd0, 0, 32'd9, 32'd9);          // BEQ
    send_op(1, 0, 3'd1, 0, 32'd9, 32'd9);          // BNE
    send_op(1, 0, 3'd2, 0, 32'd3, 32'd4);          // illegal branch
    send_op(0, 0, 3'd1, 1, 32'd3, 32'd4);          // illegal SLL
    wait_drain();

    // Back-to-back stream of 8 with out_ready low for cycles 3..5
    saw_backpressure = 0;
    rdy_mode = 2;
    stall_base = cyc;
    for (int i = 0; i < 8; i++) send_random();
    wait_drain();
    chk("stall_backpressure_seen", {31'd0, saw_backpressure}, 32'd1);
    rdy_mode = 0;

    // Random traffic with random back-pressure and idle gaps
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send_random();
      if ($urandom % 6 == 0) begin
        @(posedge clk);
        #1;
      end
    end
    wait_drain();
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Reset with two ops in flight
    send_op(0, 0, 3'd0, 0, 32'd1, 32'd2);
    send_op(0, 0, 3'd4, 0, 32'd1, 32'd2);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    inflight = 0;
    exp_ovf = '0;
    stalled_prev = 0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_ovf_count", 32'(ovf_count), 32'd0);
    chk("midrst_out_result", out_result, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_op(0, 0, 3'd0, 0, 32'd100, 32'd23);
    @(posedge clk);
    #1;
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_result", out_result, 32'd123);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
